// File: rtl/hazard_render_pipe_if.sv
// Pixel stream, hazard geometry and registered colour/collision outputs of hazard_render_pipe.
// The master drives coordinates and geometry; the slave (renderer) returns RGB and collision status.
interface hazard_render_pipe_if #(
  parameter int NUM_SPIKES  = 4,
  parameter int NUM_COLUMNS = 2
);
  logic                       pix_valid;
  logic                       frame_start;
  logic [9:0]                 DrawX;
  logic [9:0]                 DrawY;
  logic [9:0]                 player_x;
  logic [9:0]                 player_y;
  logic [9:0]                 player_size;
  logic [11*NUM_SPIKES-1:0]   spike_x;
  logic [11*NUM_SPIKES-1:0]   spike_y;
  logic [NUM_SPIKES-1:0]      spike_flip;
  logic [11*NUM_COLUMNS-1:0]  col_x;
  logic [10*NUM_COLUMNS-1:0]  col_gap_y;
  logic                       flash_en;
  logic [7:0]                 Red;
  logic [7:0]                 Green;
  logic [7:0]                 Blue;
  logic                       rgb_valid;
  logic                       hit_pixel;
  logic                       collision;

  modport master (
    output pix_valid, frame_start, DrawX, DrawY,
    output player_x, player_y, player_size,
    output spike_x, spike_y, spike_flip, col_x, col_gap_y, flash_en,
    input  Red, Green, Blue, rgb_valid, hit_pixel, collision
  );

  modport slave (
    input  pix_valid, frame_start, DrawX, DrawY,
    input  player_x, player_y, player_size,
    input  spike_x, spike_y, spike_flip, col_x, col_gap_y, flash_en,
    output Red, Green, Blue, rgb_valid, hit_pixel, collision
  );
endinterface

// File: rtl/hazard_render_pipe.sv
// Two-stage hazard renderer: stage 1 registers per-pixel geometry flags, stage 2 registers RGB.
// Also folds player/hazard overlap into a per-frame collision flag.
module hazard_render_pipe #(
  parameter int NUM_SPIKES  = 4,
  parameter int NUM_COLUMNS = 2,
  parameter int SPIKE_H     = 13,
  parameter int SLOPE_SHIFT = 1,
  parameter int COL_HALF_W  = 4,
  parameter int GAP_HALF    = 90,
  parameter int CEIL_Y      = 42,
  parameter int FLOOR_Y     = 437
) (
  input  logic              Clk,
  input  logic              Reset_n,
  hazard_render_pipe_if.slave bus
);

  typedef logic signed [11:0] s12_t;

  localparam s12_t SPIKE_H_S   = s12_t'(SPIKE_H);
  localparam s12_t SPIKE_TOP_S = s12_t'(SPIKE_H - 1);
  localparam s12_t COL_HW_S    = s12_t'(COL_HALF_W);
  localparam s12_t GAP_HALF_S  = s12_t'(GAP_HALF);
  localparam s12_t CEIL_Y_S    = s12_t'(CEIL_Y);
  localparam s12_t FLOOR_Y_S   = s12_t'(FLOOR_Y);
  localparam s12_t ONE_S       = s12_t'(1);

  localparam logic [23:0] RGB_HAZARD = 24'h00F9FF;
  localparam logic [23:0] RGB_FLASH  = 24'hFF0000;
  localparam logic [23:0] RGB_WALL   = 24'hFFFFFF;
  localparam logic [23:0] RGB_PLAYER = 24'hFF5500;

  function automatic s12_t ext10(input logic [9:0] v);
    return s12_t'({2'b00, v});
  endfunction

  function automatic s12_t ext11(input logic [10:0] v);
    return s12_t'({1'b0, v});
  endfunction

  // Operands never reach -2048, so negation cannot overflow.
  function automatic s12_t abs12(input s12_t v);
    return v[11] ? -v : v;
  endfunction

  s12_t x_s, y_s;
  assign x_s = ext10(bus.DrawX);
  assign y_s = ext10(bus.DrawY);

  logic spike_c, col_c, fc_c, pl_c;

  // Edges are tested as distances from the hazard rather than as absolute
  // bounds, so an 11-bit position plus extent can never wrap onto the screen.
  always_comb begin
    s12_t r, a, e, dx, dy;
    r       = '0;
    a       = '0;
    e       = '0;
    dx      = '0;
    dy      = '0;
    spike_c = 1'b0;
    col_c   = 1'b0;
    fc_c    = (y_s <= CEIL_Y_S) || (y_s >= FLOOR_Y_S);

    for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
      r  = y_s - ext11(bus.spike_y[11*i +: 11]);
      a  = bus.spike_flip[i] ? (SPIKE_TOP_S - r) : r;
      e  = (a >>> SLOPE_SHIFT) + ONE_S;
      dx = x_s - ext11(bus.spike_x[11*i +: 11]);
      if (!r[11] && (r < SPIKE_H_S) && (dx >= -e) && (dx <= e))
        spike_c = 1'b1;
    end

    for (int unsigned j = 0; j < NUM_COLUMNS; j++) begin
      dx = x_s - ext11(bus.col_x[11*j +: 11]);
      dy = y_s - ext10(bus.col_gap_y[10*j +: 10]);
      if ((abs12(dx) <= COL_HW_S) && (abs12(dy) >= GAP_HALF_S) && !fc_c)
        col_c = 1'b1;
    end

    pl_c = (abs12(x_s - ext10(bus.player_x)) <= ext10(bus.player_size)) &&
           (abs12(y_s - ext10(bus.player_y)) <= ext10(bus.player_size));
  end

  logic s1_valid, s1_haz, s1_fc, s1_pl;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_haz   <= 1'b0;
      s1_fc    <= 1'b0;
      s1_pl    <= 1'b0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_haz   <= spike_c | col_c;
      s1_fc    <= fc_c;
      s1_pl    <= pl_c;
    end
  end

  logic        hit_s1;
  logic        collision_q;
  logic [23:0] rgb_c;

  assign hit_s1 = s1_valid & s1_pl & s1_haz;

  always_comb begin
    rgb_c = '0;
    if (s1_valid) begin
      if (s1_haz)
        rgb_c = (bus.flash_en && collision_q) ? RGB_FLASH : RGB_HAZARD;
      else if (s1_fc)
        rgb_c = RGB_WALL;
      else if (s1_pl)
        rgb_c = RGB_PLAYER;
    end
  end

  logic [23:0] rgb_q;
  logic        rgb_valid_q;
  logic        hit_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      rgb_q       <= rgb_c;
      rgb_valid_q <= s1_valid;
      hit_q       <= hit_s1;
    end
  end

  logic acc_q;

  // A stage-2 hit was already folded into acc (or the previous report) when it
  // sat in stage 1, so only the stage-1 hit is still uncounted at frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q       <= 1'b0;
      collision_q <= 1'b0;
    end else if (bus.frame_start) begin
      collision_q <= acc_q | hit_s1;
      acc_q       <= 1'b0;
    end else begin
      acc_q       <= acc_q | hit_s1;
    end
  end

  assign bus.Red       = rgb_q[23:16];
  assign bus.Green     = rgb_q[15:8];
  assign bus.Blue      = rgb_q[7:0];
  assign bus.rgb_valid = rgb_valid_q;
  assign bus.hit_pixel = hit_q;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_hazard_render_pipe.sv
// Self-checking bench for hazard_render_pipe: directed geometry cases plus randomized
// pixels compared against an integer-arithmetic reference of the rendering rules.
module tb_hazard_render_pipe;
  localparam int NS = 8;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_render_pipe_if #(.NUM_SPIKES(NS), .NUM_COLUMNS(NC)) bus();

  hazard_render_pipe #(.NUM_SPIKES(NS), .NUM_COLUMNS(NC)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference geometry (plain integers)
  int m_sx[NS], m_sy[NS];
  bit m_fl[NS];
  int m_cx[NC], m_cgy[NC];
  int m_px, m_py, m_ps;

  typedef struct packed { logic v; logic haz; logic fc; logic pl; } cls_t;

  cls_t        pend;      // pixel presented last cycle, now in flight
  logic [25:0] exp_out;   // {rgb_valid, hit_pixel, rgb} expected right now
  logic        m_acc, m_coll;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic cls_t classify(int x, int y, logic v);
    cls_t c;
    int r, a, e;
    c.v   = v;
    c.fc  = (y <= 42) || (y >= 437);
    c.haz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      r = y - m_sy[i];
      if (r >= 0 && r < 13) begin
        a = m_fl[i] ? 12 - r : r;
        e = a / 2 + 1;
        if (x >= m_sx[i] - e && x <= m_sx[i] + e) c.haz = 1'b1;
      end
    end
    for (int j = 0; j < NC; j++)
      if (iabs(x - m_cx[j]) <= 4 && iabs(y - m_cgy[j]) >= 90 && !c.fc) c.haz = 1'b1;
    c.pl = (iabs(x - m_px) <= m_ps) && (iabs(y - m_py) <= m_ps);
    return c;
  endfunction

  function automatic logic [25:0] render(cls_t c, logic fl, logic coll);
    logic [23:0] rgb;
    rgb = 24'h0;
    if (c.v) begin
      if (c.haz)     rgb = (fl && coll) ? 24'hFF0000 : 24'h00F9FF;
      else if (c.fc) rgb = 24'hFFFFFF;
      else if (c.pl) rgb = 24'hFF5500;
    end
    return {c.v, c.v & c.pl & c.haz, rgb};
  endfunction

  task automatic set_geom();
    for (int i = 0; i < NS; i++) begin
      bus.spike_x[11*i +: 11] = 11'(m_sx[i]);
      bus.spike_y[11*i +: 11] = 11'(m_sy[i]);
      bus.spike_flip[i]       = m_fl[i];
    end
    for (int j = 0; j < NC; j++) begin
      bus.col_x[11*j +: 11]     = 11'(m_cx[j]);
      bus.col_gap_y[10*j +: 10] = 10'(m_cgy[j]);
    end
    bus.player_x    = 10'(m_px);
    bus.player_y    = 10'(m_py);
    bus.player_size = 10'(m_ps);
  endtask

  task automatic clear_geom();
    for (int i = 0; i < NS; i++) begin m_sx[i] = 2000; m_sy[i] = 0; m_fl[i] = 0; end
    for (int j = 0; j < NC; j++) begin m_cx[j] = 2000; m_cgy[j] = 0; end
    m_px = 1000; m_py = 1000; m_ps = 0;
    set_geom();
  endtask

  task automatic clear_model();
    m_acc = 1'b0; m_coll = 1'b0; pend = '0; exp_out = '0;
  endtask

  // Advance one clock; the reference tracks the pixel in flight and the frame flag.
  task automatic tick();
    cls_t        now_c;
    logic [25:0] nxt;
    logic        fs;
    now_c = classify(bus.DrawX, bus.DrawY, bus.pix_valid);
    fs    = bus.frame_start;
    nxt   = render(pend, bus.flash_en, m_coll);
    @(posedge clk); #1;
    exp_out = nxt;
    if (fs) begin m_coll = m_acc | nxt[24]; m_acc = 1'b0; end
    else m_acc = m_acc | nxt[24];
    pend = now_c;
  endtask

  task automatic drive(int x, int y, logic v, logic fs);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y);
    bus.pix_valid = v; bus.frame_start = fs;
    tick();
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_geom();
    m_sx[0] = 320; m_sy[0] = 240; set_geom();
    hard_reset();
    repeat (3) drive(320, 240, 1'b1, 1'b0);
    rst_n = 1'b0; #1;
    clear_model();
    checks++;
    if ({bus.rgb_valid, bus.hit_pixel, bus.collision, bus.Red, bus.Green, bus.Blue} !== 27'h0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", {bus.rgb_valid, bus.hit_pixel, bus.collision, bus.Red, bus.Green, bus.Blue});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(320, 240, 1'b1, 1'b0);
    checks++;
    if (bus.rgb_valid !== 1'b0) begin
      errors++; $display("FAIL rgb_valid_lat1 got %b want 0", bus.rgb_valid);
    end
    drive(0, 0, 1'b0, 1'b0);
    checks++;
    if ({bus.rgb_valid, bus.Red, bus.Green, bus.Blue} !== {1'b1, 24'h00F9FF}) begin
      errors++; $display("FAIL rgb_valid_lat2 got %h want 100f9ff", {bus.rgb_valid, bus.Red, bus.Green, bus.Blue});
    end
  endtask

  task automatic test_spike();
    int tab[14][4];
    tab = '{'{319,240,0,'h00F9FF}, '{321,240,0,'h00F9FF}, '{322,240,0,0}, '{318,240,0,0},
            '{313,252,0,'h00F9FF}, '{327,252,0,'h00F9FF}, '{312,252,0,0}, '{328,252,0,0},
            '{320,253,0,0},        '{320,239,0,0},
            '{313,240,1,'h00F9FF}, '{312,240,1,0},        '{322,252,1,0}, '{321,252,1,'h00F9FF}};
    clear_geom();
    m_sx[0] = 320; m_sy[0] = 240; set_geom();
    for (int y = 238; y <= 254; y++)
      for (int x = 310; x <= 330; x++) begin
        drive(x, y, 1'b1, 1'b0);
        checks++;
        if ({bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision} !== {exp_out, m_coll}) begin
          errors++;
          $display("FAIL spike_sweep x=%0d y=%0d got %h want %h", x, y,
                   {bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision}, {exp_out, m_coll});
        end
      end
    for (int k = 0; k < 14; k++) begin
      m_fl[0] = tab[k][2] != 0; set_geom();
      drive(tab[k][0], tab[k][1], 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      checks++;
      if ({bus.Red, bus.Green, bus.Blue} !== 24'(tab[k][3])) begin
        errors++;
        $display("FAIL spike_pt x=%0d y=%0d flip=%0d got %h want %h", tab[k][0], tab[k][1], tab[k][2],
                 {bus.Red, bus.Green, bus.Blue}, 24'(tab[k][3]));
      end
    end
  endtask

  task automatic test_column();
    int tab[8][3];
    tab = '{'{100,150,'h00F9FF}, '{100,200,0}, '{96,330,'h00F9FF}, '{95,330,0},
            '{100,20,'hFFFFFF},  '{104,150,'h00F9FF}, '{105,150,0}, '{100,450,'hFFFFFF}};
    clear_geom();
    m_cx[0] = 100; m_cgy[0] = 240; set_geom();
    for (int k = 0; k < 8; k++) begin
      drive(tab[k][0], tab[k][1], 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      checks++;
      if ({bus.Red, bus.Green, bus.Blue} !== 24'(tab[k][2])) begin
        errors++;
        $display("FAIL column_pt x=%0d y=%0d got %h want %h", tab[k][0], tab[k][1],
                 {bus.Red, bus.Green, bus.Blue}, 24'(tab[k][2]));
      end
    end
  endtask

  task automatic test_collision();
    int hp;
    clear_geom();
    m_sx[0] = 320; m_sy[0] = 240; m_px = 320; m_py = 246; m_ps = 4; set_geom();
    bus.flash_en = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      hp = 0;
      bus.flash_en = (pass == 1);
      if (pass == 1) begin m_px = 500; m_py = 300; set_geom(); end
      for (int y = 236; y <= 256; y++)
        for (int x = 310; x <= 330; x++) begin
          drive(x, y, 1'b1, 1'b0);
          hp += int'(bus.hit_pixel);
          checks++;
          if ({bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision} !== {exp_out, m_coll}) begin
            errors++;
            $display("FAIL coll_sweep pass=%0d x=%0d y=%0d got %h want %h", pass, x, y,
                     {bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision}, {exp_out, m_coll});
          end
        end
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1);
      checks++;
      if (bus.collision !== (pass == 0)) begin
        errors++; $display("FAIL frame_collision pass=%0d got %b want %b", pass, bus.collision, pass == 0);
      end
      if (pass == 0) begin
        checks++;
        if (hp == 0) begin errors++; $display("FAIL hit_pulses got %0d want >0", hp); end
      end
    end
    // Flash tint: collision=1 and flash_en turns hazards red
    m_px = 320; m_py = 246; set_geom();
    bus.flash_en = 1'b1;
    drive(320, 246, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    drive(320, 240, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    checks++;
    if ({bus.collision, bus.Red, bus.Green, bus.Blue} !== {1'b1, 24'hFF0000}) begin
      errors++; $display("FAIL flash_red got %h want 1ff0000", {bus.collision, bus.Red, bus.Green, bus.Blue});
    end
    bus.flash_en = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL back_to_back got %b want 0", bus.collision);
    end
  endtask

  task automatic test_fs_overlap();
    drive(320, 246, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (bus.collision !== 1'b1) begin
      errors++; $display("FAIL fs_stage1_old_frame got %b want 1", bus.collision);
    end
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL fs_new_acc_clear got %b want 0", bus.collision);
    end
    drive(320, 246, 1'b1, 1'b1);
    checks++;
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL fs_same_cycle_pixel got %b want 0", bus.collision);
    end
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (bus.collision !== 1'b1) begin
      errors++; $display("FAIL fs_pixel_new_frame got %b want 1", bus.collision);
    end
  endtask

  task automatic test_reset_midframe();
    repeat (3) drive(320, 246, 1'b1, 1'b0);
    hard_reset();
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL reset_acc_discard got %b want 0", bus.collision);
    end
    drive(320, 246, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (bus.collision !== 1'b1) begin
      errors++; $display("FAIL reset_then_hit got %b want 1", bus.collision);
    end
  endtask

  task automatic test_offscreen();
    int haz_px;
    haz_px = 0;
    clear_geom();
    for (int i = 0; i < NS; i++) begin m_sx[i] = (i % 2 == 0) ? 700 : 1084; m_sy[i] = 230; end
    m_cx[0] = 700; m_cx[1] = 1084; m_cgy[0] = 0; m_cgy[1] = 0;
    m_px = 60; m_py = 235; m_ps = 12; set_geom();
    drive(0, 0, 1'b0, 1'b1);
    for (int y = 225; y <= 245; y++)
      for (int x = 50; x <= 70; x++) begin
        drive(x, y, 1'b1, 1'b0);
        if (bus.Green == 8'hF9) haz_px++;
        checks++;
        if ({bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision} !== {exp_out, m_coll}) begin
          errors++;
          $display("FAIL offscreen_sweep x=%0d y=%0d got %h want %h", x, y,
                   {bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision}, {exp_out, m_coll});
        end
      end
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    checks++;
    if (haz_px != 0 || bus.collision !== 1'b0) begin
      errors++; $display("FAIL offscreen_alias haz_px=%0d coll=%b want 0 0", haz_px, bus.collision);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 12; seg++) begin
      for (int i = 0; i < NS; i++) begin
        m_sx[i] = (i == NS - 1) ? int'($urandom_range(0, 2047)) : int'($urandom_range(100, 200));
        m_sy[i] = $urandom_range(100, 200);
        m_fl[i] = $urandom_range(0, 1) != 0;
      end
      for (int j = 0; j < NC; j++) begin
        m_cx[j] = $urandom_range(100, 200); m_cgy[j] = $urandom_range(100, 300);
      end
      m_px = $urandom_range(100, 200); m_py = $urandom_range(100, 200); m_ps = $urandom_range(0, 15);
      set_geom();
      bus.flash_en = $urandom_range(0, 1) != 0;
      for (int n = 0; n < 60; n++) begin
        drive($urandom_range(90, 210), $urandom_range(90, 210),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        checks++;
        if ({bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision} !== {exp_out, m_coll}) begin
          errors++;
          $display("FAIL random seg=%0d n=%0d got %h want %h", seg, n,
                   {bus.rgb_valid, bus.hit_pixel, bus.Red, bus.Green, bus.Blue, bus.collision}, {exp_out, m_coll});
        end
      end
    end
  endtask

  initial begin
    bus.pix_valid = 1'b0; bus.frame_start = 1'b0; bus.flash_en = 1'b0;
    bus.DrawX = '0; bus.DrawY = '0;
    clear_geom();
    clear_model();
    @(posedge clk); #1;
    test_reset();
    test_spike();
    test_column();
    test_collision();
    test_fs_overlap();
    test_reset_midframe();
    test_offscreen();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
